// File: rtl/piso_serializer.sv
// rtl/piso_serializer.sv - parallel-in/serial-out frame serializer with serial receive capture
module piso_serializer #(
    parameter int WIDTH      = 8,
    parameter bit MSB_FIRST  = 1'b1,
    parameter bit IDLE_LEVEL = 1'b1
) (
    input  logic             Clock,
    input  logic             rst,
    input  logic [WIDTH-1:0] data,
    input  logic             load_valid,
    output logic             load_ready,
    input  logic             shift_en,
    input  logic             flush,
    input  logic             sIn,
    output logic             sOut,
    output logic             sOut_valid,
    output logic             frame_done,
    output logic [WIDTH-1:0] rx_data,
    output logic             busy
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] sr;
    logic [WIDTH-1:0] sr_next;
    logic [CW-1:0]    cnt;
    logic             last_bit;
    logic             advance;

    assign last_bit = (cnt == LAST);
    assign advance  = (state == SHIFT) && shift_en;

    // Shift register contents after one advancing edge, with sIn entering at the far end
    always_comb begin
        sr_next = sr;
        if (MSB_FIRST) begin
            sr_next = {sr[WIDTH-2:0], sIn};
        end else begin
            sr_next = {sIn, sr[WIDTH-1:1]};
        end
    end

    // Handshake and status are suppressed by reset and flush so no transfer or frame end is reported
    assign frame_done = !rst && !flush && advance && last_bit;
    assign load_ready = !rst && !flush && ((state == IDLE) || (advance && last_bit));
    assign sOut_valid = !rst && (state == SHIFT);
    assign busy       = sOut_valid;
    assign sOut       = sOut_valid ? (MSB_FIRST ? sr[WIDTH-1] : sr[0]) : IDLE_LEVEL;

    // Frame state machine: load, shift, capture on the last bit, chain or return to idle
    always_ff @(posedge Clock) begin
        if (rst) begin
            state   <= IDLE;
            sr      <= '0;
            cnt     <= '0;
            rx_data <= '0;
        end else if (flush) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (load_valid) begin
                        sr    <= data;
                        cnt   <= '0;
                        state <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (shift_en) begin
                        if (last_bit) begin
                            rx_data <= sr_next;
                            cnt     <= '0;
                            if (load_valid) begin
                                sr <= data;
                            end else begin
                                sr    <= sr_next;
                                state <= IDLE;
                            end
                        end else begin
                            sr  <= sr_next;
                            cnt <= cnt + CW'(1);
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                    cnt   <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_piso_serializer.sv
// tb/tb_piso_serializer.sv - directed vector bench for piso_serializer
module tb_piso_serializer;

    logic       Clock = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] data = 8'h00;
    logic       load_valid = 1'b0;
    logic       shift_en = 1'b0;
    logic       flush = 1'b0;
    logic       sIn = 1'b0;

    logic       load_ready, sOut, sOut_valid, frame_done, busy;
    logic [7:0] rx_data;
    logic       load_ready_l, sOut_l, sOut_valid_l, frame_done_l, busy_l;
    logic [7:0] rx_data_l;

    always #5 Clock = ~Clock;

    piso_serializer #(.WIDTH(8), .MSB_FIRST(1'b1), .IDLE_LEVEL(1'b1)) dut (
        .Clock(Clock), .rst(rst), .data(data), .load_valid(load_valid), .load_ready(load_ready),
        .shift_en(shift_en), .flush(flush), .sIn(sIn), .sOut(sOut), .sOut_valid(sOut_valid),
        .frame_done(frame_done), .rx_data(rx_data), .busy(busy)
    );

    piso_serializer #(.WIDTH(8), .MSB_FIRST(1'b0), .IDLE_LEVEL(1'b0)) dut_lsb (
        .Clock(Clock), .rst(rst), .data(data), .load_valid(load_valid), .load_ready(load_ready_l),
        .shift_en(shift_en), .flush(flush), .sIn(sIn), .sOut(sOut_l), .sOut_valid(sOut_valid_l),
        .frame_done(frame_done_l), .rx_data(rx_data_l), .busy(busy_l)
    );

    typedef struct {
        logic       rst, lv, se, fl, sin;
        logic [7:0] d;
        logic       lr, so, sov, fd;
        logic [7:0] rx;
    } vec_t;

    vec_t vecs[$];
    int   n_vec = 0;
    int   n_err = 0;

    localparam logic [7:0] P85 = 8'h85;
    localparam logic [7:0] PA5 = 8'hA5;
    localparam logic [7:0] P5A = 8'h5A;
    localparam logic [7:0] PC3 = 8'hC3;
    localparam logic [7:0] P3C = 8'h3C;
    localparam logic [7:0] PF0 = 8'hF0;
    localparam logic [7:0] P96 = 8'h96;

    task automatic add(input logic r, lv, input logic [7:0] d, input logic se, fl, sin,
                       input logic lr, so, sov, fd, input logic [7:0] rx);
        vec_t v;
        v.rst = r; v.lv = lv; v.d = d; v.se = se; v.fl = fl; v.sin = sin;
        v.lr = lr; v.so = so; v.sov = sov; v.fd = fd; v.rx = rx;
        vecs.push_back(v);
    endtask

    task automatic chk(input string name, input int idx, input logic [7:0] act, input logic [7:0] exp);
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s step %0d: got %h expected %h", name, idx, act, exp);
        end
    endtask

    initial begin
        // frame 0x85 with sIn = 0xA5, MSB first
        add(1, 0, 8'h00, 0, 0, 0,  0, 1, 0, 0, 8'h00);
        add(1, 1, P85,   1, 0, 0,  0, 1, 0, 0, 8'h00);
        add(0, 1, P85,   1, 0, 0,  1, 1, 0, 0, 8'h00);
        for (int k = 1; k <= 8; k++)
            add(0, 0, 8'h00, 1, 0, PA5[8-k], k == 8, P85[8-k], 1, k == 8, 8'h00);
        add(0, 0, 8'h00, 0, 0, 0,  1, 1, 0, 0, PA5);

        // back-to-back frames 0x85 then 0x3C, receiving 0x5A then 0xC3
        add(0, 1, P85, 1, 0, 0,  1, 1, 0, 0, PA5);
        for (int k = 1; k <= 8; k++)
            add(0, k == 8, (k == 8) ? P3C : 8'h00, 1, 0, P5A[8-k], k == 8, P85[8-k], 1, k == 8, PA5);
        for (int k = 9; k <= 16; k++)
            add(0, 0, 8'h00, 1, 0, PC3[16-k], k == 16, P3C[16-k], 1, k == 16, P5A);
        add(0, 0, 8'h00, 0, 0, 0,  1, 1, 0, 0, PC3);

        // shift_en alternating 0,1: bits held two cycles, loads ignored while stalled
        add(0, 1, PF0, 0, 0, 0,  1, 1, 0, 0, PC3);
        for (int j = 1; j <= 16; j++) begin
            if (j % 2 == 0)
                add(0, 0, 8'h00, 1, 0, P96[8-j/2], j == 16, PF0[7-(j-1)/2], 1, j == 16, PC3);
            else
                add(0, 1, 8'hFF, 0, 0, ~P96[8-(j+1)/2], 0, PF0[7-(j-1)/2], 1, 0, PC3);
        end
        add(0, 0, 8'h00, 0, 0, 0,  1, 1, 0, 0, P96);

        // flush after bit 3 with a pending load
        add(0, 1, P85, 1, 0, 0,  1, 1, 0, 0, P96);
        for (int k = 1; k <= 3; k++)
            add(0, 0, 8'h00, 1, 0, 1, 0, P85[8-k], 1, 0, P96);
        add(0, 1, 8'h11, 1, 1, 1,  0, P85[4], 1, 0, P96);
        add(0, 0, 8'h00, 0, 0, 0,  1, 1, 0, 0, P96);

        // flush on the last bit suppresses frame_done and rx capture
        add(0, 1, P85, 1, 0, 0,  1, 1, 0, 0, P96);
        for (int k = 1; k <= 7; k++)
            add(0, 0, 8'h00, 1, 0, 1, 0, P85[8-k], 1, 0, P96);
        add(0, 0, 8'h00, 1, 1, 1,  0, P85[0], 1, 0, P96);
        add(0, 0, 8'h00, 0, 0, 0,  1, 1, 0, 0, P96);

        // flush in idle blocks a load
        add(0, 1, P85, 1, 1, 0,  0, 1, 0, 0, P96);
        add(0, 0, 8'h00, 0, 0, 0,  1, 1, 0, 0, P96);

        // reset mid-frame clears rx_data
        add(0, 1, P85, 1, 0, 0,  1, 1, 0, 0, P96);
        for (int k = 1; k <= 3; k++)
            add(0, 0, 8'h00, 1, 0, 1, 0, P85[8-k], 1, 0, P96);
        add(1, 1, 8'h11, 1, 1, 1,  0, 1, 0, 0, P96);
        add(0, 0, 8'h00, 0, 0, 0,  1, 1, 0, 0, 8'h00);

        rst = 1'b1;
        repeat (2) @(posedge Clock);

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge Clock);
            rst = vecs[i].rst; load_valid = vecs[i].lv; data = vecs[i].d;
            shift_en = vecs[i].se; flush = vecs[i].fl; sIn = vecs[i].sin;
            #1;
            n_vec++;
            chk("load_ready", i, {7'b0, load_ready}, {7'b0, vecs[i].lr});
            chk("sOut",       i, {7'b0, sOut},       {7'b0, vecs[i].so});
            chk("sOut_valid", i, {7'b0, sOut_valid}, {7'b0, vecs[i].sov});
            chk("busy",       i, {7'b0, busy},       {7'b0, vecs[i].sov});
            chk("frame_done", i, {7'b0, frame_done}, {7'b0, vecs[i].fd});
            chk("rx_data",    i, rx_data,            vecs[i].rx);
        end

        // LSB-first instance with idle level 0: frame 0x85, sIn = 0xA5 LSB first
        @(negedge Clock);
        rst = 1'b1; load_valid = 1'b0; flush = 1'b0; shift_en = 1'b0; sIn = 1'b0;
        #1;
        n_vec++;
        chk("lsb_idle_sOut",  100, {7'b0, sOut_l},       8'h00);
        chk("lsb_idle_valid", 100, {7'b0, sOut_valid_l}, 8'h00);
        @(negedge Clock);
        rst = 1'b0; load_valid = 1'b1; data = P85; shift_en = 1'b1;
        #1;
        n_vec++;
        chk("lsb_accept_ready", 101, {7'b0, load_ready_l}, 8'h01);
        chk("lsb_accept_sOut",  101, {7'b0, sOut_l},       8'h00);
        for (int k = 1; k <= 8; k++) begin
            @(negedge Clock);
            load_valid = 1'b0; data = 8'h00; shift_en = 1'b1; sIn = PA5[k-1];
            #1;
            n_vec++;
            chk("lsb_sOut",       101 + k, {7'b0, sOut_l},       {7'b0, P85[k-1]});
            chk("lsb_valid",      101 + k, {7'b0, sOut_valid_l}, 8'h01);
            chk("lsb_frame_done", 101 + k, {7'b0, frame_done_l}, {7'b0, k == 8});
        end
        @(negedge Clock);
        shift_en = 1'b0; sIn = 1'b0;
        #1;
        n_vec++;
        chk("lsb_rx_data", 110, rx_data_l,             PA5);
        chk("lsb_end_sOut", 110, {7'b0, sOut_l},       8'h00);
        chk("lsb_end_busy", 110, {7'b0, busy_l},       8'h00);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
